// File: rtl/audio_pkg.sv
// Shared audio-path definitions: Q22.10 fixed-point format, tau width and the tau picker state type.
package audio_pkg;

  localparam int FRACTION_WIDTH = 10;
  localparam int TAU_WIDTH      = 11;
  localparam int CMNDF_WIDTH    = 32;

  // 1.0 in unsigned Q22.10.
  localparam logic [CMNDF_WIDTH-1:0] CMNDF_ONE = CMNDF_WIDTH'(1) << FRACTION_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    DIP    = 3'd2,
    DRAIN  = 3'd3,
    EMIT   = 3'd4
  } picker_state_e;

  // A frame is in progress between its first accepted value and the emit cycle.
  function automatic logic is_frame_active(input picker_state_e s);
    return (s == SEARCH) || (s == DIP) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/tau_picker_if.sv
// Bus between the CMNDF producer and the tau picker: d'(tau) stream in, selected period out.
interface tau_picker_if;
  import audio_pkg::*;

  // cmndf_valid_in qualifies cmndf_in/cmndf_last_in; there is no ready, every valid cycle
  // is a transfer. tau_valid_out is a one-cycle pulse qualifying tau_out/voiced_out.
  logic                   frame_start_in;
  logic [CMNDF_WIDTH-1:0] cmndf_in;
  logic                   cmndf_valid_in;
  logic                   cmndf_last_in;
  logic [TAU_WIDTH-1:0]   tau_out;
  logic                   tau_valid_out;
  logic                   voiced_out;
  logic                   busy_out;
  picker_state_e          state_dbg;

  modport master (
    output frame_start_in, cmndf_in, cmndf_valid_in, cmndf_last_in,
    input  tau_out, tau_valid_out, voiced_out, busy_out, state_dbg
  );

  modport slave (
    input  frame_start_in, cmndf_in, cmndf_valid_in, cmndf_last_in,
    output tau_out, tau_valid_out, voiced_out, busy_out, state_dbg
  );

endinterface

// File: rtl/tau_picker_min_tracker.sv
// Global-minimum tracker over tau >= MIN_TAU (strict <, earliest tau wins).
// Only compiled when TAU_PICKER_GLOBAL_MIN_EN is defined.
`ifdef TAU_PICKER_GLOBAL_MIN_EN
module min_tracker
  import audio_pkg::*;
#(
  parameter int MIN_TAU = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [CMNDF_WIDTH-1:0] val,
  input  logic [TAU_WIDTH-1:0]   tau,
  output logic [TAU_WIDTH-1:0]   min_tau_next
);

  localparam logic [TAU_WIDTH-1:0] MIN_TAU_T = TAU_WIDTH'(MIN_TAU);

  logic [CMNDF_WIDTH-1:0] min_val_q, min_val_d, base_val;
  logic [TAU_WIDTH-1:0]   min_tau_q, min_tau_d, base_tau;

  // clear restarts the search in the same cycle, so a value arriving with it still counts.
  always_comb begin
    base_val  = clear ? '1 : min_val_q;
    base_tau  = clear ? '0 : min_tau_q;
    min_val_d = base_val;
    min_tau_d = base_tau;
    if (valid && (tau >= MIN_TAU_T) && (val < base_val)) begin
      min_val_d = val;
      min_tau_d = tau;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      min_val_q <= '1;
      min_tau_q <= '0;
    end else begin
      min_val_q <= min_val_d;
      min_tau_q <= min_tau_d;
    end
  end

  assign min_tau_next = min_tau_d;

endmodule
`endif

// File: rtl/tau_picker.sv
// YIN period picker: selects the first threshold dip of d'(tau) in each frame.
// Define TAU_PICKER_GLOBAL_MIN_EN to emit the global minimum (unvoiced) for frames without a dip.
module tau_picker
  import audio_pkg::*;
#(
  parameter int                     WINDOW_SIZE = 2048,
  parameter logic [CMNDF_WIDTH-1:0] THRESHOLD   = 32'd102,
  parameter int                     MIN_TAU     = 32
) (
  input logic         clk_in,
  input logic         rst_in,
  tau_picker_if.slave bus
);

  localparam logic [TAU_WIDTH-1:0] LAST_TAU  = TAU_WIDTH'(WINDOW_SIZE - 1);
  localparam logic [TAU_WIDTH-1:0] MIN_TAU_T = TAU_WIDTH'(MIN_TAU);
  localparam logic [TAU_WIDTH-1:0] FIRST_TAU = TAU_WIDTH'(1);

  picker_state_e          state_q, state_d, base_state;
  logic [CMNDF_WIDTH-1:0] best_val_q, best_val_d, base_val;
  logic [TAU_WIDTH-1:0]   best_tau_q, best_tau_d, base_tau;
  logic [TAU_WIDTH-1:0]   tau_cnt_q, tau_cnt_d, cur_tau;
  logic [TAU_WIDTH-1:0]   tau_q, tau_d;
  logic                   voiced_q, voiced_d;
  logic                   tau_valid_q, emit_d;
  logic                   busy_q, busy_d;
  logic                   fresh, frame_end, dip_seen;

  // Outside a frame (idle, emit cycle, or abort) the incoming value is tau=1 of a new frame.
  assign fresh     = bus.frame_start_in || (state_q == IDLE) || (state_q == EMIT);
  assign cur_tau   = fresh ? FIRST_TAU : (tau_cnt_q + FIRST_TAU);
  assign frame_end = bus.cmndf_valid_in && (bus.cmndf_last_in || (cur_tau == LAST_TAU));

`ifdef TAU_PICKER_GLOBAL_MIN_EN
  logic [TAU_WIDTH-1:0] gmin_tau_next;

  min_tracker #(
    .MIN_TAU (MIN_TAU)
  ) u_min_tracker (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear        (fresh),
    .valid        (bus.cmndf_valid_in),
    .val          (bus.cmndf_in),
    .tau          (cur_tau),
    .min_tau_next (gmin_tau_next)
  );
`endif

  always_comb begin
    base_state = fresh ? IDLE : state_q;
    base_val   = fresh ? '1 : best_val_q;
    base_tau   = fresh ? '0 : best_tau_q;
    state_d    = base_state;
    best_val_d = base_val;
    best_tau_d = base_tau;
    tau_cnt_d  = fresh ? '0 : tau_cnt_q;
    tau_d      = tau_q;
    voiced_d   = voiced_q;
    emit_d     = 1'b0;
    dip_seen   = 1'b0;

    if (bus.cmndf_valid_in) begin
      tau_cnt_d = cur_tau;
      case (base_state)
        IDLE, SEARCH: begin
          if ((bus.cmndf_in < THRESHOLD) && (cur_tau >= MIN_TAU_T)) begin
            best_val_d = bus.cmndf_in;
            best_tau_d = cur_tau;
            state_d    = DIP;
          end else begin
            state_d = SEARCH;
          end
        end
        DIP: begin
          // Ties end the dip so the earliest tau of a plateau is kept.
          if (bus.cmndf_in < base_val) begin
            best_val_d = bus.cmndf_in;
            best_tau_d = cur_tau;
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN:   state_d = DRAIN;
        default: state_d = SEARCH;
      endcase

      // The final value is folded in first, so a still-falling dip reports its last tau.
      if (frame_end) begin
        tau_cnt_d = '0;
        dip_seen  = (state_d == DIP) || (state_d == DRAIN);
        if (dip_seen) begin
          state_d  = EMIT;
          emit_d   = 1'b1;
          tau_d    = best_tau_d;
          voiced_d = 1'b1;
        end else begin
`ifdef TAU_PICKER_GLOBAL_MIN_EN
          state_d  = EMIT;
          emit_d   = 1'b1;
          tau_d    = gmin_tau_next;
          voiced_d = 1'b0;
`else
          state_d  = IDLE;
`endif
        end
      end
    end

    busy_d = is_frame_active(state_d);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      best_val_q  <= '1;
      best_tau_q  <= '0;
      tau_cnt_q   <= '0;
      tau_q       <= '0;
      voiced_q    <= 1'b0;
      tau_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_val_q  <= best_val_d;
      best_tau_q  <= best_tau_d;
      tau_cnt_q   <= tau_cnt_d;
      tau_q       <= tau_d;
      voiced_q    <= voiced_d;
      tau_valid_q <= emit_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.tau_out       = tau_q;
  assign bus.voiced_out    = voiced_q;
  assign bus.tau_valid_out = tau_valid_q;
  assign bus.busy_out      = busy_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_tau_picker.sv
// Self-checking bench for tau_picker: frame table plus hand-written abort and reset sequences.
module tb_tau_picker;
  import audio_pkg::*;

  localparam int W = 44;

  typedef struct {
    int sc;
    int n;
    bit use_last;
    bit gap;
    bit pulse;
    int tau;
    bit voiced;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hold_tau = 0;
  bit   hold_voiced = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  vec_t vecs[8];

  tau_picker_if bus ();

  tau_picker #(
    .WINDOW_SIZE (2048),
    .THRESHOLD   (32'd102),
    .MIN_TAU     (32)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: record every pulse with the cycle it appeared in.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && bus.tau_valid_out === 1'b1)
      obs_q.push_back({32'(cyc), bus.voiced_out, bus.tau_out});
  end

  // ---------------- stimulus model ----------------
  function automatic logic [31:0] gen(input int sc, input int t);
    logic [31:0] v;
    v = CMNDF_ONE;
    case (sc)
      0:  if (t == 100) v = 90; else if (t == 101) v = 60; else if (t == 102) v = 80;
      1:  if (t == 10) v = 5; else if (t == 200) v = 50;
      2:  if (t == 500) v = 300;
      3:  if (t >= 40 && t <= 42) v = 60;
      4:  if (t >= 45 && t <= 50) v = 32'(100 - (t - 45) * 5);
      7:  if (t == 2040) v = 50; else if (t == 2041) v = 40; else if (t == 2042) v = 45;
      8:  if (t == 31) v = 10; else if (t == 32) v = 20;
      9:  if (t == 40) v = 102; else if (t == 45) v = 101;
      10: if (t == 250) v = 40;
      11: if (t == 150) v = 30;
      12: if (t == 80) v = 90; else if (t == 81) v = 80; else if (t == 82) v = 70;
      default: v = CMNDF_ONE;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] v, input logic last, input logic fs, input logic vld);
    @(posedge clk_in);
    #1;
    bus.cmndf_in       = v;
    bus.cmndf_valid_in = vld;
    bus.cmndf_last_in  = last;
    bus.frame_start_in = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // The value just driven is accepted at the next edge; the pulse follows one cycle later.
  task automatic expect_pulse(input int tau, input bit voiced);
    exp_q.push_back({32'(cyc + 1), voiced, 11'(tau)});
    hold_tau    = tau;
    hold_voiced = voiced;
  endtask

  task automatic run_frame(input int sc, input int n, input bit use_last, input bit fs_first,
                           input bit pulse, input int tau, input bit voiced);
    for (int t = 1; t <= n; t++) begin
      drive(gen(sc, t), use_last && (t == n), fs_first && (t == 1), 1'b1);
      if (t == 2) chk($sformatf("busy_sc%0d", sc), 64'(bus.busy_out), 64'd1);
      if (t == n && pulse) expect_pulse(tau, voiced);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain_check(input string name);
    logic [W-1:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s_missing: no pulse, expected tau=%0d voiced=%0d cycle=%0d",
                 name, e[10:0], e[11], e[43:12]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s_pulse: actual tau=%0d voiced=%0d cycle=%0d expected tau=%0d voiced=%0d cycle=%0d",
                   name, o[10:0], o[11], o[43:12], e[10:0], e[11], e[43:12]);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_extra: unexpected pulse tau=%0d voiced=%0d cycle=%0d expected none",
               name, o[10:0], o[11], o[43:12]);
    end
  endtask

  task automatic settle_and_check(input string name);
    idle(3);
    drain_check(name);
    chk({name, "_tau_hold"}, 64'(bus.tau_out), 64'(hold_tau));
    chk({name, "_voiced_hold"}, 64'(bus.voiced_out), 64'(hold_voiced));
    chk({name, "_busy_idle"}, 64'(bus.busy_out), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{sc: 0, n: 2047, use_last: 1, gap: 1, pulse: 1, tau: 101,  voiced: 1};
    vecs[1] = '{sc: 1, n: 300,  use_last: 1, gap: 1, pulse: 1, tau: 200,  voiced: 1};
`ifdef TAU_PICKER_GLOBAL_MIN_EN
    vecs[2] = '{sc: 2, n: 600,  use_last: 1, gap: 1, pulse: 1, tau: 500,  voiced: 0};
`else
    vecs[2] = '{sc: 2, n: 600,  use_last: 1, gap: 1, pulse: 0, tau: 0,    voiced: 0};
`endif
    vecs[3] = '{sc: 3, n: 100,  use_last: 1, gap: 0, pulse: 1, tau: 40,   voiced: 1};
    vecs[4] = '{sc: 4, n: 50,   use_last: 1, gap: 1, pulse: 1, tau: 50,   voiced: 1};
    vecs[5] = '{sc: 7, n: 2047, use_last: 0, gap: 1, pulse: 1, tau: 2041, voiced: 1};
    vecs[6] = '{sc: 8, n: 60,   use_last: 1, gap: 1, pulse: 1, tau: 32,   voiced: 1};
    vecs[7] = '{sc: 9, n: 60,   use_last: 1, gap: 1, pulse: 1, tau: 45,   voiced: 1};

    rst_in             = 1'b0;
    bus.frame_start_in = 1'b0;
    bus.cmndf_in       = '0;
    bus.cmndf_valid_in = 1'b0;
    bus.cmndf_last_in  = 1'b0;
    #12;
    chk("rst_tau", 64'(bus.tau_out), 64'd0);
    chk("rst_valid", 64'(bus.tau_valid_out), 64'd0);
    chk("rst_voiced", 64'(bus.voiced_out), 64'd0);
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_state", 64'(bus.state_dbg), 64'(IDLE));
    rst_in = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].sc, vecs[i].n, vecs[i].use_last, 1'b0,
                vecs[i].pulse, vecs[i].tau, vecs[i].voiced);
      if (vecs[i].gap) settle_and_check($sformatf("vec%0d", i));
    end

    // Abort frame A (dip already found) at tau=300; frame B starts with frame_start on its first value.
    run_frame(10, 299, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(11, 400, 1'b1, 1'b1, 1'b1, 150, 1'b1);
    settle_and_check("abort");

    // Reset while a dip is open, then a clean frame.
    run_frame(12, 82, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_state", 64'(bus.state_dbg), 64'(DIP));
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst_tau", 64'(bus.tau_out), 64'd0);
    chk("async_rst_voiced", 64'(bus.voiced_out), 64'd0);
    chk("async_rst_valid", 64'(bus.tau_valid_out), 64'd0);
    chk("async_rst_busy", 64'(bus.busy_out), 64'd0);
    chk("async_rst_state", 64'(bus.state_dbg), 64'(IDLE));
    idle(2);
    rst_in      = 1'b1;
    hold_tau    = 0;
    hold_voiced = 1'b0;
    drain_check("during_rst");
    run_frame(3, 100, 1'b1, 1'b0, 1'b1, 40, 1'b1);
    settle_and_check("post_rst");

    chk("queues_empty", 64'(exp_q.size() + obs_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tau_picker.md
TAU_PICKER -- requirements
Module: tau_picker

Interface
REQ-001 Parameter WINDOW_SIZE, default 2048: frame length; the maximum tau is WINDOW_SIZE-1.
REQ-002 Parameter THRESHOLD, default 32'd102: dip threshold, unsigned Q22.10 (0.1).
REQ-003 Parameter MIN_TAU, default 32: values with tau < MIN_TAU are counted but never selected.
REQ-004 Port clk_in, input, 1: sole clock; all logic is rising-edge.
REQ-005 Port rst_in, input, 1: asynchronous, active-low reset.
REQ-006 Port frame_start_in, input, 1: one-cycle pulse that aborts any frame in progress and rearms the counter.
REQ-007 Port cmndf_in, input, 32: cumulative-mean-normalized difference d'(tau), unsigned Q22.10.
REQ-008 Port cmndf_valid_in, input, 1: cmndf_in is valid this cycle; always accepted, no backpressure.
REQ-009 Port cmndf_last_in, input, 1: qualifies the final value of the frame.
REQ-010 Port tau_out, output, 11: selected period in samples.
REQ-011 Port tau_valid_out, output, 1: one-cycle pulse; tau_out and voiced_out are valid.
REQ-012 Port voiced_out, output, 1: 1 means the tau came from a threshold dip.
REQ-013 Port busy_out, output, 1: high from the first accepted value until the emit cycle.

Function
REQ-014 FSM states: IDLE, SEARCH, DIP, DRAIN, EMIT (typedef picker_state_e).
- The first valid value after reset, frame_start_in or EMIT is tau=1; each further valid value increments tau.
- frame_start_in together with a valid value makes that value tau=1.
REQ-015 SEARCH: on a value < THRESHOLD with tau >= MIN_TAU, latch best_val/best_tau and go to DIP.
REQ-016 DIP:
- A value strictly less than best_val updates best_val/best_tau.
- A value >= best_val ends the dip (ties keep the earliest tau); go to DRAIN with voiced=1.
REQ-017 DRAIN: ignore values until cmndf_last_in.
REQ-018 Frame end (cmndf_last_in accepted, or tau reaching WINDOW_SIZE-1) from any state → EMIT; a dip still open at that point is treated as ended, voiced=1.
REQ-019 EMIT: lasts exactly one cycle, 1 cycle after the last value is accepted; tau_valid_out=1; then → IDLE.
REQ-020 tau_out and voiced_out register at EMIT and hold until the next EMIT.
REQ-021 frame_start_in in any non-EMIT state clears best_val, best_tau and the global minimum, and → IDLE; no emission occurs.
REQ-022 A valid value arriving during EMIT is tau=1 of the next frame.
REQ-023 Comparisons are full 32-bit unsigned; the counter is 11 bits and never wraps.

Reset
REQ-024 rst_in low asynchronously forces:
- state=IDLE, tau_out=0, tau_valid_out=0, voiced_out=0, busy_out=0;
- all internal registers to 0, except best_val/global minimum to all-ones.
REQ-025 Deassertion mid-stream: subsequent values are treated as a new frame starting at tau=1.

Configuration
REQ-026 With TAU_PICKER_GLOBAL_MIN_EN defined:
- The global minimum over tau >= MIN_TAU is tracked (strict <, earliest tau wins).
- A frame with no dip emits that tau with voiced_out=0.
REQ-027 Without TAU_PICKER_GLOBAL_MIN_EN:
- A no-dip frame produces no tau_valid_out pulse; tau_out/voiced_out hold their previous values.
- No global-minimum logic is synthesized.

Structure
REQ-028 A shared package audio_pkg holds FRACTION_WIDTH=10, TAU_WIDTH=11 and picker_state_e.
REQ-029 The global-minimum tracker is a natural sub-module, min_tracker, instantiated only under TAU_PICKER_GLOBAL_MIN_EN.

Verification
REQ-030 Bench directed scenarios:
- Stream tau=1..2047: d'=1024 everywhere, except tau=100..102 = 90,60,80 → tau_out=101, voiced_out=1, one pulse 1 cycle after last.
- Dip at tau=10 (value 5) plus dip at tau=200 (value 50), MIN_TAU=32 → tau_out=200.
- No value below 102, minimum 300 at tau=500:
  - macro on → tau_out=500, voiced_out=0;
  - macro off → no pulse, tau_out unchanged.
- Plateau 60,60,60 at tau=40..42 → tau_out=40. A dip still falling when cmndf_last_in arrives at tau=50 → tau_out=50, voiced_out=1.
- frame_start_in at tau=300 of frame A, then full frame B with dip at 150 → single pulse, tau_out=150.
- rst_in asserted during DIP → outputs 0 immediately; the next frame is detected correctly.
